// File: rtl/bitplane_feeder.sv
// Bit-plane feeder: serializes activation vectors MSB-first and gates weights onto the adder tree.
// Optional leading-zero plane skipping is enabled by defining LEAD_ZERO_SKIP_EN.
module bitplane_feeder #(
   parameter  int N_LANE = 32,
   parameter  int ACT_W  = 4,
   parameter  int WGT_W  = 4,
   localparam int IDX_W  = (ACT_W > 1) ? $clog2(ACT_W) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_LANE*ACT_W-1:0]   act_flat,
   input  logic [N_LANE*WGT_W-1:0]   wgt_flat,
   output logic [N_LANE*WGT_W-1:0]   tw_flat,
   output logic                      tw_valid,
   output logic                      tw_first,
   output logic                      tw_last,
   output logic [IDX_W-1:0]          tw_bit,
   output logic                      busy
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

   state_t                    state_r, state_n_s;
   logic [N_LANE*ACT_W-1:0]   act_r, act_n_s, sh_act_r, sh_act_n_s;
   logic [N_LANE*WGT_W-1:0]   wgt_r, wgt_n_s, sh_wgt_r, sh_wgt_n_s;
   logic                      sh_full_r, sh_full_n_s;
   logic [IDX_W-1:0]          bit_idx_r, bit_idx_n_s;
   logic [IDX_W-1:0]          start_idx_r, start_idx_n_s;
   logic [IDX_W-1:0]          start_in_s, start_sh_s;
   logic                      accept_s, last_s;
   logic [N_LANE*WGT_W-1:0]   tw_flat_s;

`ifdef LEAD_ZERO_SKIP_EN
   // Highest bit position set in any lane; 0 when every activation is zero.
   function automatic logic [IDX_W-1:0] lead_idx(input logic [N_LANE*ACT_W-1:0] act);
      logic [ACT_W-1:0] any_v;
      logic [IDX_W-1:0] idx_v;
      any_v = '0;
      idx_v = '0;
      for (int i = 0; i < N_LANE; i++) begin
         any_v = any_v | act[i*ACT_W +: ACT_W];
      end
      for (int b = 0; b < ACT_W; b++) begin
         if (any_v[b]) begin
            idx_v = IDX_W'(b);
         end else begin
            idx_v = idx_v;
         end
      end
      return idx_v;
   endfunction
`endif

   assign accept_s = in_valid && !sh_full_r;
   assign last_s   = (state_r == ST_STREAM) && (bit_idx_r == IDX_W'(0));

   // Start plane for a vector loaded from the input port or from the shadow buffer.
   always_comb begin
`ifdef LEAD_ZERO_SKIP_EN
      start_in_s = lead_idx(act_flat);
      start_sh_s = lead_idx(sh_act_r);
`else
      start_in_s = IDX_W'(ACT_W-1);
      start_sh_s = IDX_W'(ACT_W-1);
`endif
   end

   // Next-state logic: plane stepping plus active/shadow buffer steering.
   always_comb begin
      state_n_s     = state_r;
      act_n_s       = act_r;
      wgt_n_s       = wgt_r;
      sh_act_n_s    = sh_act_r;
      sh_wgt_n_s    = sh_wgt_r;
      sh_full_n_s   = sh_full_r;
      bit_idx_n_s   = bit_idx_r;
      start_idx_n_s = start_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               act_n_s       = act_flat;
               wgt_n_s       = wgt_flat;
               bit_idx_n_s   = start_in_s;
               start_idx_n_s = start_in_s;
               state_n_s     = ST_STREAM;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (!last_s) begin
               bit_idx_n_s = bit_idx_r - IDX_W'(1);
               if (accept_s) begin
                  sh_act_n_s  = act_flat;
                  sh_wgt_n_s  = wgt_flat;
                  sh_full_n_s = 1'b1;
               end else begin
                  sh_full_n_s = sh_full_r;
               end
            end else if (sh_full_r) begin
               act_n_s       = sh_act_r;
               wgt_n_s       = sh_wgt_r;
               sh_full_n_s   = 1'b0;
               bit_idx_n_s   = start_sh_s;
               start_idx_n_s = start_sh_s;
            end else if (accept_s) begin
               // Bypass the shadow so back-to-back vectors stream without a bubble.
               act_n_s       = act_flat;
               wgt_n_s       = wgt_flat;
               bit_idx_n_s   = start_in_s;
               start_idx_n_s = start_in_s;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // State and buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         act_r       <= '0;
         wgt_r       <= '0;
         sh_act_r    <= '0;
         sh_wgt_r    <= '0;
         sh_full_r   <= 1'b0;
         bit_idx_r   <= '0;
         start_idx_r <= '0;
      end else begin
         state_r     <= state_n_s;
         act_r       <= act_n_s;
         wgt_r       <= wgt_n_s;
         sh_act_r    <= sh_act_n_s;
         sh_wgt_r    <= sh_wgt_n_s;
         sh_full_r   <= sh_full_n_s;
         bit_idx_r   <= bit_idx_n_s;
         start_idx_r <= start_idx_n_s;
      end
   end

   // Per-lane weight gating by the current activation bit.
   always_comb begin
      tw_flat_s = '0;
      for (int i = 0; i < N_LANE; i++) begin
         logic [ACT_W-1:0] lane_act_v;
         lane_act_v = act_r[i*ACT_W +: ACT_W];
         if ((state_r == ST_STREAM) && lane_act_v[bit_idx_r]) begin
            tw_flat_s[i*WGT_W +: WGT_W] = wgt_r[i*WGT_W +: WGT_W];
         end else begin
            tw_flat_s[i*WGT_W +: WGT_W] = '0;
         end
      end
   end

   assign tw_flat  = tw_flat_s;
   assign tw_valid = (state_r == ST_STREAM);
   assign tw_first = tw_valid && (bit_idx_r == start_idx_r);
   assign tw_last  = last_s;
   assign tw_bit   = bit_idx_r;
   assign busy     = (state_r == ST_STREAM) || sh_full_r;
   assign in_ready = !sh_full_r;

endmodule

// File: tb/tb_bitplane_feeder.sv
// Self-checking bench for bitplane_feeder: directed cases then random traffic,
// compared against a plane-queue reference model.
module tb_bitplane_feeder;

   localparam int N  = 32;
   localparam int AW = 4;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*AW-1:0] act_flat = '0;
   logic [N*WW-1:0] wgt_flat = '0;
   logic [N*WW-1:0] tw_flat;
   logic            tw_valid, tw_first, tw_last, busy;
   logic [1:0]      tw_bit;

   bitplane_feeder #(.N_LANE(N), .ACT_W(AW), .WGT_W(WW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .act_flat(act_flat), .wgt_flat(wgt_flat), .tw_flat(tw_flat),
      .tw_valid(tw_valid), .tw_first(tw_first), .tw_last(tw_last),
      .tw_bit(tw_bit), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*WW-1:0] flat;
      logic            first;
      logic            last;
      logic [1:0]      bitn;
   } plane_t;

   plane_t  pq[$];
   int      checks = 0;
   int      errors = 0;
   longint  o_acc = 0;
   longint  last_o = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int held_vectors();
      int c = 0;
      foreach (pq[k]) if (pq[k].last) c++;
      return c;
   endfunction

   // Expand a vector into the planes it should produce, most significant first.
   task automatic push_vec(input logic [N*AW-1:0] a, input logic [N*WW-1:0] w);
      logic [AW-1:0] orv;
      int st;
      plane_t p;
      orv = '0;
      for (int i = 0; i < N; i++) orv = orv | a[i*AW +: AW];
`ifdef LEAD_ZERO_SKIP_EN
      st = 0;
      for (int b = 0; b < AW; b++) if (orv[b]) st = b;
`else
      st = AW - 1;
`endif
      for (int b = st; b >= 0; b--) begin
         p.flat = '0;
         for (int i = 0; i < N; i++)
            if (a[i*AW + b]) p.flat[i*WW +: WW] = w[i*WW +: WW];
         p.first = (b == st);
         p.last  = (b == 0);
         p.bitn  = 2'(b);
         pq.push_back(p);
      end
   endtask

   task automatic check_all();
      plane_t e;
      longint psum;
      if (pq.size() > 0) begin
         e = pq[0];
         check_val("tw_valid", tw_valid, 1'b1);
      end else begin
         e.flat = '0; e.first = 1'b0; e.last = 1'b0; e.bitn = 2'd0;
         check_val("tw_valid", tw_valid, 1'b0);
      end
      check_val("tw_flat", tw_flat, e.flat);
      check_val("tw_first", tw_first, e.first);
      check_val("tw_last", tw_last, e.last);
      check_val("tw_bit", tw_bit, e.bitn);
      check_val("busy", busy, pq.size() > 0);
      check_val("in_ready", in_ready, held_vectors() < 2);
      if (tw_valid) begin
         psum = 0;
         for (int i = 0; i < N; i++) psum += longint'(tw_flat[i*WW +: WW]);
         o_acc = tw_first ? psum : psum + (o_acc << 1);
         if (tw_last) last_o = o_acc;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check on the falling edge.
   task automatic step(input logic v, input logic r, input logic [N*AW-1:0] a,
                       input logic [N*WW-1:0] w, output logic accepted);
      in_valid = v; rst = r; act_flat = a; wgt_flat = w;
      accepted = v && !r && (held_vectors() < 2);
      @(posedge clk);
      if (r) begin
         pq.delete();
      end else begin
         if (pq.size() > 0) void'(pq.pop_front());
         if (accepted) push_vec(a, w);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic offer(input logic [N*AW-1:0] a, input logic [N*WW-1:0] w);
      logic acc;
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
         step(1'b1, 1'b0, a, w, acc);
         tries++;
      end
      check_val("offer_accepted", acc, 1'b1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, acc);
   endtask

   initial begin
      logic            acc;
      logic [AW-1:0]   a4;
      logic [WW-1:0]   w4;
      logic [N*AW-1:0] ra;
      logic [N*WW-1:0] rw;
      int              mode;

      step(1'b0, 1'b1, '0, '0, acc);
      step(1'b1, 1'b1, {32{4'hF}}, {32{4'hF}}, acc);

      a4 = 4'hA; w4 = 4'h3;
      offer({N{a4}}, {N{w4}});
      idle(6);
      check_val("o_single", last_o, 960);

      offer({N{4'hF}}, {N{4'h1}});
      offer({N{4'h1}}, {N{4'h2}});
      idle(9);

      offer({N{4'h5}}, {N{4'h7}});
      offer({N{4'h9}}, {N{4'h4}});
      offer({N{4'h6}}, {N{4'hB}});
      idle(14);

      offer({{(N*AW-4){1'b0}}, 4'h8}, {N{4'hF}});
      idle(5);

      offer({N{4'hC}}, {N{4'h2}});
      offer({N{4'h3}}, {N{4'h5}});
      step(1'b1, 1'b1, {N{4'hF}}, {N{4'hF}}, acc);
      offer({N{4'hB}}, {N{4'h6}});
      idle(6);

      offer({N{4'h3}}, {N{4'h1}});
      idle(5);
      offer('0, {N{4'hF}});
      idle(3);

      for (int n = 0; n < 3000; n++) begin
         for (int j = 0; j < 4; j++) begin
            ra[j*32 +: 32] = $urandom;
            rw[j*32 +: 32] = $urandom;
         end
         mode = $urandom_range(0, 5);
         case (mode)
            0: ra = ra & {N{4'h3}};
            1: ra = ra & {N{4'h1}};
            2: ra = '0;
            default: ra = ra;
         endcase
         step($urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0, ra, rw, acc);
      end
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
